// File: rtl/bsg_credit_pool_arbiter.sv
// Round-robin arbiter that issues at most one grant per cycle from a shared pool
// of up-down credits; each grant takes one credit, and returns come back in bulk.
module bsg_credit_pool_arbiter #(
  parameter int els_p          = 4,
  parameter int max_credits_p  = 16,
  parameter int init_credits_p = 16,
  parameter int max_return_p   = 4,
  localparam int cnt_width_lp  = $clog2(max_credits_p + 1),
  localparam int ret_width_lp  = $clog2(max_return_p + 1),
  localparam int id_width_lp   = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [els_p-1:0]        v_i,
  output logic [els_p-1:0]        yumi_o,
  output logic                    grant_v_o,
  output logic [id_width_lp-1:0]  grant_id_o,
  input  logic                    stall_i,
  input  logic [ret_width_lp-1:0] credit_return_i,
  output logic [cnt_width_lp-1:0] credits_o,
  output logic                    credits_zero_o,
  output logic                    overflow_o
);

  localparam int sum_width_lp = cnt_width_lp + 1;

  logic [cnt_width_lp-1:0] r_credits;
  logic [id_width_lp-1:0]  r_rr_ptr;
  logic                    r_overflow;

  logic                    w_hi_found;
  logic                    w_lo_found;
  logic [id_width_lp-1:0]  w_hi_id;
  logic [id_width_lp-1:0]  w_lo_id;
  logic                    w_found;
  logic [id_width_lp-1:0]  w_win;
  logic                    w_grant;
  logic [sum_width_lp-1:0] w_sum;
  logic                    w_ovf;
  logic [id_width_lp-1:0]  w_ptr_next;

  // Split the scan at the pointer: requesters at or above it win over those below.
  // Scanning downward lets the lowest index in each half overwrite the others.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_id    = '0;
    w_lo_id    = '0;
    for (int k = els_p - 1; k >= 0; k--) begin
      if (v_i[k]) begin
        if (k >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_id    = id_width_lp'(k);
        end else begin
          w_lo_found = 1'b1;
          w_lo_id    = id_width_lp'(k);
        end
      end
    end
  end

  assign w_found = w_hi_found | w_lo_found;
  assign w_win   = w_hi_found ? w_hi_id : w_lo_id;

  // Returns never enable a same-cycle grant: only the registered pool is consulted.
  assign w_grant = w_found & ~stall_i & (r_credits != '0) & ~reset_i;

  assign grant_v_o  = w_grant;
  assign grant_id_o = w_grant ? w_win : '0;
  assign yumi_o     = w_grant ? (els_p'(1) << w_win) : '0;

  assign w_sum = {1'b0, r_credits}
               - sum_width_lp'(w_grant)
               + sum_width_lp'(credit_return_i);
  assign w_ovf = (w_sum > sum_width_lp'(max_credits_p));

  assign w_ptr_next = (w_win == id_width_lp'(els_p - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_credits  <= cnt_width_lp'(init_credits_p);
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_credits  <= w_ovf ? cnt_width_lp'(max_credits_p) : w_sum[cnt_width_lp-1:0];
      r_overflow <= r_overflow | w_ovf;
      if (w_grant) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  assign credits_o      = r_credits;
  assign credits_zero_o = (r_credits == '0);
  assign overflow_o     = r_overflow;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      if (credit_return_i > ret_width_lp'(max_return_p)) begin
        $error("bsg_credit_pool_arbiter: credit_return_i=%0d above max_return_p=%0d",
               credit_return_i, max_return_p);
      end
      if (!r_overflow && w_ovf) begin
        $display("bsg_credit_pool_arbiter: pool clamped at %0d, overflow_o now set",
                 max_credits_p);
      end
    end
  end
`endif

endmodule
